// File: rtl/buffer_loader_pkg.sv
// buf_pkg: FSM state type and default configuration widths shared by
// buffer_loader, its address generator and its bus interface.
`ifndef N_BUF
`define N_BUF 4
`endif
`ifndef ADDR_RAM
`define ADDR_RAM 8
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

package buf_pkg;
    localparam int DEF_N_BUF  = `N_BUF;
    localparam int DEF_ADDR_W = `ADDR_RAM;
    localparam int DEF_DATA_W = `WID_PE_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Bank-select width; kept at least 1 so a single-bank build still has a port
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int nb_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/buffer_loader_if.sv
// buffer_loader_if: control, input stream and write-port signals of
// buffer_loader; the DUT side is the slave modport.
interface buffer_loader_if #(
    parameter int N_BUF  = buf_pkg::DEF_N_BUF,
    parameter int ADDR_W = buf_pkg::DEF_ADDR_W,
    parameter int DATA_W = buf_pkg::DEF_DATA_W
) ();
    localparam int SEL_W = buf_pkg::sel_w(N_BUF);
    localparam int NB_W  = buf_pkg::nb_w(N_BUF);

    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [ADDR_W:0]   i_len;
    logic [NB_W-1:0]   i_num_buf;
    logic              i_abort;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    logic              o_wr_valid;
    logic [SEL_W-1:0]  o_wr_sel;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_busy;
    logic              o_done;
    logic              o_cfg_err;

    modport master (
        output i_start, i_base_addr, i_len, i_num_buf, i_abort,
        output i_in_valid, i_in_data,
        input  o_in_ready, o_wr_valid, o_wr_sel, o_wr_addr, o_wr_data,
        input  o_busy, o_done, o_cfg_err
    );

    modport slave (
        input  i_start, i_base_addr, i_len, i_num_buf, i_abort,
        input  i_in_valid, i_in_data,
        output o_in_ready, o_wr_valid, o_wr_sel, o_wr_addr, o_wr_data,
        output o_busy, o_done, o_cfg_err
    );
endinterface

// File: rtl/buffer_loader_addr_gen.sv
// buf_addr_gen: bank/offset counters, wrapped write address and the
// last-word flag for the buffer loader.
module buf_addr_gen
    import buf_pkg::*;
#(
    parameter int N_BUF  = DEF_N_BUF,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEL_W  = sel_w(N_BUF),
    parameter int NB_W   = nb_w(N_BUF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    input  logic [NB_W-1:0]   i_num_buf,
    output logic [SEL_W-1:0]  o_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    logic [SEL_W-1:0]  r_bank;
    logic [ADDR_W-1:0] r_off;
    logic [ADDR_W:0]   w_len_m1;
    logic [NB_W-1:0]   w_nb_m1;
    logic              w_off_end;
    logic              w_bank_end;

    assign w_len_m1   = i_len - (ADDR_W+1)'(1);
    assign w_nb_m1    = i_num_buf - NB_W'(1);
    assign w_off_end  = ({1'b0, r_off} == w_len_m1);
    assign w_bank_end = (NB_W'(r_bank) == w_nb_m1);

    // Address wraps modulo 2^ADDR_W by truncation of the sum
    assign o_addr = i_base + r_off;
    assign o_sel  = r_bank;
    assign o_last = w_off_end && w_bank_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank <= '0;
            r_off  <= '0;
        end else if (i_clear) begin
            r_bank <= '0;
            r_off  <= '0;
        end else if (i_step) begin
            if (w_off_end) begin
                r_off  <= '0;
                r_bank <= r_bank + SEL_W'(1);
            end else begin
                r_off <= r_off + ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/buffer_loader.sv
// buffer_loader: streams words into N_BUF banks via a serial write port.
// Define BUFFER_LOADER_CKSUM_EN to add the o_cksum XOR output.
module buffer_loader
    import buf_pkg::*;
#(
    parameter int N_BUF  = DEF_N_BUF,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    buffer_loader_if.slave    bus
`ifdef BUFFER_LOADER_CKSUM_EN
    ,
    output logic [DATA_W-1:0] o_cksum
`endif
);
    localparam int SEL_W = sel_w(N_BUF);
    localparam int NB_W  = nb_w(N_BUF);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [NB_W-1:0]   r_num_buf;
    logic              r_wr_valid;
    logic [SEL_W-1:0]  r_wr_sel;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_cfg_err;
    logic              w_idle_start;
    logic              w_cfg_bad;
    logic              w_cfg_empty;
    logic              w_accept;
    logic              w_write;
    logic              w_last;
    logic [SEL_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_addr;

    assign w_idle_start = bus.i_start && (r_state == ST_IDLE);
    assign w_cfg_bad    = bus.i_num_buf > NB_W'(N_BUF);
    assign w_cfg_empty  = (bus.i_len == '0) || (bus.i_num_buf == '0);
    assign w_accept     = bus.i_in_valid && (r_state == ST_LOAD);
    // Abort suppresses the write of a word accepted in the same cycle
    assign w_write      = w_accept && !bus.i_abort;

    buf_addr_gen #(
        .N_BUF  (N_BUF),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_idle_start),
        .i_step    (w_write),
        .i_base    (r_base),
        .i_len     (r_len),
        .i_num_buf (r_num_buf),
        .o_sel     (w_sel),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_idle_start && !w_cfg_bad)
                    w_next = w_cfg_empty ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.i_abort)
                    w_next = ST_IDLE;
                else if (w_accept && w_last)
                    w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_num_buf <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle_start) begin
                r_base    <= bus.i_base_addr;
                r_len     <= bus.i_len;
                r_num_buf <= bus.i_num_buf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_sel   <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_wr_valid <= w_write;
            r_cfg_err  <= w_idle_start && w_cfg_bad;
            if (w_write) begin
                r_wr_sel  <= w_sel;
                r_wr_addr <= w_addr;
                r_wr_data <= bus.i_in_data;
            end
        end
    end

`ifdef BUFFER_LOADER_CKSUM_EN
    logic [DATA_W-1:0] r_cksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cksum <= '0;
        else if (w_idle_start && !w_cfg_bad)
            r_cksum <= '0;
        else if (w_write)
            r_cksum <= r_cksum ^ bus.i_in_data;
    end

    assign o_cksum = r_cksum;
`endif

    assign bus.o_in_ready = (r_state == ST_LOAD);
    assign bus.o_busy     = (r_state == ST_LOAD);
    assign bus.o_done     = (r_state == ST_DONE);
    assign bus.o_wr_valid = r_wr_valid;
    assign bus.o_wr_sel   = r_wr_sel;
    assign bus.o_wr_addr  = r_wr_addr;
    assign bus.o_wr_data  = r_wr_data;
    assign bus.o_cfg_err  = r_cfg_err;
endmodule

// File: doc/buffer_loader.md
BUFFER_LOADER -- requirements
Module: buffer_loader

Interface
REQ-001 Param N_BUF, default `N_BUF, number of memory banks in the downstream buffer.
REQ-002 Param ADDR_W, default `ADDR_RAM, bank address width.
REQ-003 Param DATA_W, default `WID_PE_BITS, word width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; samples base_addr, len and num_buf.
REQ-007 base_addr  in  ADDR_W  first bank address written in every bank.
REQ-008 len  in  ADDR_W+1  words per bank, 0..2^ADDR_W.
REQ-009 num_buf  in  $clog2(N_BUF)+1  banks to fill, in order from bank 0.
REQ-010 abort  in  1  terminates an active load.
REQ-011 in_valid / in_ready / in_data  in / out / in  1 / 1 / DATA_W  serial input stream.
REQ-012 wr_valid  out  1  registered write strobe toward the buffer serial (mode 0) write port.
REQ-013 wr_sel  out  $clog2(N_BUF)  target bank index, valid when wr_valid=1.
REQ-014 wr_addr / wr_data  out  ADDR_W / DATA_W  write address and data, valid with wr_valid.
REQ-015 busy  out  1  high in LOAD; done  out  1  one-cycle completion pulse; cfg_err  out  1  one-cycle error pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD and DONE.
REQ-017 IDLE->LOAD on start with len>0, 1<=num_buf<=N_BUF; latch config; clear bank and offset counters.
REQ-018 start with len=0 or num_buf=0 SHALL go IDLE->DONE with no writes.
REQ-019 start with num_buf>N_BUF SHALL pulse cfg_err the next cycle, stay IDLE, no writes.
REQ-020 in_ready SHALL equal 1 exactly in LOAD; a word is accepted when in_valid&&in_ready.
REQ-021 Each accepted word SHALL produce wr_valid=1 on the following cycle (latency 1) with wr_sel=bank counter, wr_addr=(base_addr+offset) mod 2^ADDR_W, wr_data=in_data.
REQ-022 Offset SHALL increment per accepted word; at offset=len-1 it SHALL return to 0 and the bank counter SHALL increment.
REQ-023 Acceptance of the word at bank num_buf-1, offset len-1 SHALL move LOAD->DONE; in_ready SHALL drop that next cycle.
REQ-024 DONE SHALL assert done for exactly one cycle, coinciding with the final wr_valid, then return to IDLE.
REQ-025 in_valid low SHALL stall counters; wr_valid SHALL be 0 on cycles with no acceptance.
REQ-026 start while in LOAD or DONE SHALL be ignored.
REQ-027 abort in LOAD SHALL return to IDLE next cycle; a word accepted the same cycle SHALL NOT be written; done SHALL NOT pulse.
REQ-028 abort and the final acceptance in the same cycle: abort SHALL win.
REQ-029 busy SHALL equal (state==LOAD).

Reset
REQ-030 rst SHALL immediately force IDLE, counters 0, and wr_valid, wr_sel, wr_addr, wr_data, busy, done, cfg_err, in_ready all 0, regardless of clock.
REQ-031 rst mid-load SHALL discard the load; no write strobe SHALL occur after rst deassertion until a new start.

Configuration
REQ-032 Macro BUFFER_LOADER_CKSUM_EN defined: output cksum (DATA_W) SHALL hold the XOR of all words written since the last accepted start, cleared on that start and on rst, final with done.
REQ-033 Macro undefined: cksum port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 FSM state enum and the cfg width constants SHALL live in the shared package buf_pkg.
REQ-035 A sub-module buf_addr_gen (bank/offset counters, address sum, last-word flag) SHALL be instantiated once; FSM and output registers stay in buffer_loader.

Verification
REQ-036 N_BUF=4, base=0x10, len=3, num_buf=2, 6 words D0..D5 back-to-back -> writes (0,0x10,D0),(0,0x11,D1),(0,0x12,D2),(1,0x10,D3),(1,0x11,D4),(1,0x12,D5); done with last write.
REQ-037 ADDR_W=4, base=0xE, len=4, num_buf=1 -> addresses 0xE,0xF,0x0,0x1.
REQ-038 in_valid toggling 1010..., len=2, num_buf=2 -> exactly 4 writes, none on idle cycles, order as REQ-036.
REQ-039 num_buf=5 with N_BUF=4 -> cfg_err one cycle, no wr_valid, busy stays 0; len=0 -> done next cycle, no writes.
REQ-040 abort after 2nd accepted word of a 6-word load -> exactly 2 writes, no done; rst mid-load -> all outputs 0 asynchronously.
REQ-041 With BUFFER_LOADER_CKSUM_EN, words 0x5,0x3,0xF -> cksum=0x9 at done.
